synthesis_pe: RTL and testbench

- Single FP16 multiply-accumulate processing element for an output-stationary systolic array.
- Passes operands A (horizontal) and B (vertical) to its neighbours through registers.
- Accumulates A×B into a local FP16 accumulator.
- Exchanges the accumulator with a partial-sum scan chain (C) on a context switch, which allows preload and readout while the next tile computes.

---
 rtl/synthesis_pe.sv | 233 +++++++++++++++++++++++
 tb/tb_synthesis_pe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/synthesis_pe.sv
// synthesis_pe: FP16 multiply-accumulate cell for an output-stationary systolic array.
// Optional build macro PE_ZERO_GATING_EN skips operand pairs that are zero or below the exponent threshold.
module synthesis_pe #(
   parameter int IA_W = 16,
   parameter int IB_W = 16,
   parameter int OC_W = 16,
   parameter int TH_W = 2
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [IA_W-1:0] i_a,
   input  logic [IB_W-1:0] i_b,
   input  logic [OC_W-1:0] i_c,
   input  logic            i_reg_clear,
   input  logic            i_cell_en,
   input  logic            i_cell_sc_en,
   input  logic            i_pipeline_en,
   input  logic            i_cswitch,
   input  logic            i_cscan_en,
   input  logic [TH_W-1:0] i_thres,
   output logic            o_cswitch,
   output logic            o_cell_en,
   output logic [IA_W-1:0] o_a,
   output logic [IB_W-1:0] o_b,
   output logic [OC_W-1:0] o_c
);

   localparam logic [15:0] QNAN = 16'h7E00;

   // Round-to-nearest-even on an 11-bit significand, then saturate to inf or flush to signed zero.
   function automatic logic [15:0] fp16_round(input logic s, input int e_in, input logic [10:0] m_in,
                                              input logic g, input logic st);
      logic [11:0] m;
      int          e;
      logic [15:0] r;
      m = {1'b0, m_in};
      e = e_in;
      if (g && (st || m_in[0])) m = m + 12'd1;
      if (m[11]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 31)     r = {s, 5'h1F, 10'h000};
      else if (e <= 0) r = {s, 15'h0000};
      else             r = {s, e[4:0], m[9:0]};
      return r;
   endfunction

   function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
      logic        s;
      logic [4:0]  ex, ey;
      logic [9:0]  mx, my;
      logic [21:0] p;
      logic [10:0] m;
      logic        g, st;
      int          e;
      logic [15:0] r;
      s  = x[15] ^ y[15];
      ex = x[14:10];
      ey = y[14:10];
      mx = x[9:0];
      my = y[9:0];
      if ((ex == 5'h1F && mx != 10'd0) || (ey == 5'h1F && my != 10'd0)) begin
         r = QNAN;
      end else if (ex == 5'h1F || ey == 5'h1F) begin
         r = (ex == 5'd0 || ey == 5'd0) ? QNAN : {s, 5'h1F, 10'h000};
      end else if (ex == 5'd0 || ey == 5'd0) begin
         r = {s, 15'h0000};
      end else begin
         p = 22'({1'b1, mx}) * 22'({1'b1, my});
         e = int'(ex) + int'(ey) - 15;
         if (p[21]) begin
            m  = p[21:11];
            g  = p[10];
            st = |p[9:0];
            e  = e + 1;
         end else begin
            m  = p[20:10];
            g  = p[9];
            st = |p[8:0];
         end
         r = fp16_round(s, e, m, g, st);
      end
      return r;
   endfunction

   // A zero addend returns the other operand untouched, so a zero product never disturbs acc.
   function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] big, sml, r;
      logic [13:0] bx, by, sh, mask, r14;
      logic [14:0] r15;
      int          e, d;
      r = x;
      if ((x[14:10] == 5'h1F && x[9:0] != 10'd0) || (y[14:10] == 5'h1F && y[9:0] != 10'd0)) begin
         r = QNAN;
      end else if (x[14:10] == 5'h1F && y[14:10] == 5'h1F) begin
         r = (x[15] != y[15]) ? QNAN : x;
      end else if (x[14:10] == 5'h1F) begin
         r = x;
      end else if (y[14:10] == 5'h1F) begin
         r = y;
      end else if (y[14:10] == 5'd0) begin
         r = x;
      end else if (x[14:10] == 5'd0) begin
         r = y;
      end else begin
         if (x[14:0] >= y[14:0]) begin
            big = x;
            sml = y;
         end else begin
            big = y;
            sml = x;
         end
         e  = int'(big[14:10]);
         d  = int'(big[14:10]) - int'(sml[14:10]);
         bx = {1'b1, big[9:0], 3'b000};
         by = {1'b1, sml[9:0], 3'b000};
         if (d >= 14) begin
            sh = 14'd1;
         end else begin
            mask  = (14'd1 << d) - 14'd1;
            sh    = by >> d;
            sh[0] = sh[0] | (|(by & mask));
         end
         if (big[15] == sml[15]) r15 = {1'b0, bx} + {1'b0, sh};
         else                    r15 = {1'b0, bx} - {1'b0, sh};
         if (r15 == 15'd0) begin
            r = 16'h0000;
         end else begin
            if (r15[14]) begin
               r14    = r15[14:1];
               r14[0] = r14[0] | r15[0];
               e      = e + 1;
            end else begin
               r14 = r15[13:0];
            end
            for (int i = 0; i < 13; i++) begin
               if (!r14[13]) begin
                  r14 = r14 << 1;
                  e   = e - 1;
               end
            end
            r = fp16_round(big[15], e, r14[13:3], r14[2], |r14[1:0]);
         end
      end
      return r;
   endfunction

   logic [IA_W-1:0] a_p1_q, a_p1_d;
   logic [IB_W-1:0] b_p1_q, b_p1_d;
   logic            cell_en_p1_q, cell_en_p1_d;
   logic            cswitch_p1_q, cswitch_p1_d;
   logic [OC_W-1:0] prod_p2_q, prod_p2_d;
   logic            vld_p2_q, vld_p2_d;
   logic [OC_W-1:0] acc_q, acc_d;
   logic [OC_W-1:0] scan_q, scan_d;
   logic [OC_W-1:0] acc_next;
   logic            cs_fire;
   logic            gated;

`ifdef PE_ZERO_GATING_EN
   function automatic logic fp16_gate(input logic [15:0] v, input logic [TH_W-1:0] th);
      return (v[14:10] == 5'd0) || (v[14:10] < 5'(th));
   endfunction

   assign gated = fp16_gate(a_p1_q, i_thres) | fp16_gate(b_p1_q, i_thres);
`else
   logic unused_thres;
   assign gated        = 1'b0;
   assign unused_thres = ^i_thres;
`endif

   assign cs_fire  = i_cswitch & i_pipeline_en;
   assign acc_next = vld_p2_q ? fp16_add(acc_q, prod_p2_q) : acc_q;

   always_comb begin
      a_p1_d       = a_p1_q;
      b_p1_d       = b_p1_q;
      cell_en_p1_d = cell_en_p1_q;
      cswitch_p1_d = cswitch_p1_q;
      prod_p2_d    = prod_p2_q;
      vld_p2_d     = vld_p2_q;
      acc_d        = acc_q;
      scan_d       = scan_q;
      if (i_pipeline_en) begin
         a_p1_d       = i_a;
         b_p1_d       = i_b;
         cell_en_p1_d = i_cell_en;
         cswitch_p1_d = i_cswitch;
         if (!gated) prod_p2_d = fp16_mul(a_p1_q, b_p1_q);
         vld_p2_d = cell_en_p1_q & ~gated;
         acc_d    = acc_next;
      end
      // Products still in flight after a switch land in the freshly loaded context.
      if (cs_fire) acc_d = i_cell_sc_en ? scan_q : '0;
      if (i_reg_clear) begin
         acc_d    = '0;
         vld_p2_d = 1'b0;
      end
      if (cs_fire)         scan_d = acc_next;
      else if (i_cscan_en) scan_d = i_c;
   end

   // Stage boundary: operand forwarding (p1), product (p2), accumulator and scan chain.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         a_p1_q       <= '0;
         b_p1_q       <= '0;
         cell_en_p1_q <= 1'b0;
         cswitch_p1_q <= 1'b0;
         prod_p2_q    <= '0;
         vld_p2_q     <= 1'b0;
         acc_q        <= '0;
         scan_q       <= '0;
      end else begin
         a_p1_q       <= a_p1_d;
         b_p1_q       <= b_p1_d;
         cell_en_p1_q <= cell_en_p1_d;
         cswitch_p1_q <= cswitch_p1_d;
         prod_p2_q    <= prod_p2_d;
         vld_p2_q     <= vld_p2_d;
         acc_q        <= acc_d;
         scan_q       <= scan_d;
      end
   end

   assign o_a       = a_p1_q;
   assign o_b       = b_p1_q;
   assign o_cell_en = cell_en_p1_q;
   assign o_cswitch = cswitch_p1_q;
   assign o_c       = scan_q;

endmodule

// File: tb/tb_synthesis_pe.sv
// Directed bench for synthesis_pe: cycle table for the control paths, arithmetic table read out through the scan register.
module tb_synthesis_pe;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] a, b, c;
   logic        clr, en, sc, pen, csw, scan;
   logic [1:0]  thres;
   logic        o_cswitch, o_cell_en;
   logic [15:0] o_a, o_b, o_c;

   int n_cmp = 0;
   int n_fail = 0;

   synthesis_pe dut (
      .i_clk(clk), .i_rstn(rstn), .i_a(a), .i_b(b), .i_c(c),
      .i_reg_clear(clr), .i_cell_en(en), .i_cell_sc_en(sc), .i_pipeline_en(pen),
      .i_cswitch(csw), .i_cscan_en(scan), .i_thres(thres),
      .o_cswitch(o_cswitch), .o_cell_en(o_cell_en), .o_a(o_a), .o_b(o_b), .o_c(o_c)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b, c;
      logic        clr, en, sc, pen, csw, scan;
      logic [15:0] ea, eb, ec;
      logic        ecsw, een;
   } vec_t;

   typedef struct {
      logic [15:0] a, b, c, exp;
   } arith_t;

   function automatic vec_t mkv(logic [15:0] va, logic [15:0] vb, logic [15:0] vc, logic vclr, logic ven,
                                logic vsc, logic vpen, logic vcsw, logic vscan, logic [15:0] xa,
                                logic [15:0] xb, logic [15:0] xc, logic xcsw, logic xen);
      vec_t v;
      v.a = va; v.b = vb; v.c = vc; v.clr = vclr; v.en = ven; v.sc = vsc; v.pen = vpen;
      v.csw = vcsw; v.scan = vscan; v.ea = xa; v.eb = xb; v.ec = xc; v.ecsw = xcsw; v.een = xen;
      return v;
   endfunction

   function automatic arith_t mka(logic [15:0] va, logic [15:0] vb, logic [15:0] vc, logic [15:0] ve);
      arith_t r;
      r.a = va; r.b = vb; r.c = vc; r.exp = ve;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [49:0] act, input logic [49:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic [15:0] va, logic [15:0] vb, logic [15:0] vc, logic vclr, logic ven,
                        logic vsc, logic vpen, logic vcsw, logic vscan);
      a = va; b = vb; c = vc; clr = vclr; en = ven; sc = vsc; pen = vpen; csw = vcsw; scan = vscan;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic [49:0] outs();
      return {o_a, o_b, o_c, o_cswitch, o_cell_en};
   endfunction

   // Preload acc with c, push one pair through, then switch it out to o_c.
   task automatic arith(input int idx, input arith_t t);
      drive(16'h0, 16'h0, t.c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(t.a, t.b, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("arith%0d %h*%h+%h", idx, t.a, t.b, t.c), 50'(o_c), 50'(t.exp));
      idle();
      tick();
   endtask

   vec_t   tbl[26];
   arith_t atb[18];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      tbl[1]  = mkv(16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      tbl[2]  = mkv(16'h3C00, 16'h4000, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h3C00, 16'h4000, 16'h0000, 0, 1);
      tbl[3]  = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      tbl[4]  = tbl[3];
      tbl[5]  = tbl[3];
      tbl[6]  = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h4000, 1, 0);
      tbl[7]  = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h4000, 0, 0);
      tbl[8]  = mkv(16'h3C00, 16'h4000, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h3C00, 16'h4000, 16'h4000, 0, 1);
      tbl[9]  = tbl[8];
      tbl[10] = tbl[8];
      tbl[11] = tbl[7];
      tbl[12] = tbl[7];
      tbl[13] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h4600, 1, 0);
      tbl[14] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h4600, 0, 0);
      tbl[15] = mkv(16'h0000, 16'h0000, 16'h4100, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h4100, 0, 0);
      tbl[16] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
      tbl[17] = tbl[3];
      tbl[18] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h4100, 1, 0);
      tbl[19] = mkv(16'h0000, 16'h0000, 16'h4200, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h4200, 0, 0);
      tbl[20] = mkv(16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
      tbl[21] = tbl[3];
      tbl[22] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
      tbl[23] = tbl[3];
      tbl[24] = mkv(16'h4000, 16'h4000, 16'h3C00, 0, 1, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h3C00, 0, 0);
      tbl[25] = mkv(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h3C00, 0, 0);

      atb[0]  = mka(16'h3C00, 16'h4000, 16'h0000, 16'h4000);
      atb[1]  = mka(16'h3C00, 16'h4000, 16'h3C00, 16'h4200);
      atb[2]  = mka(16'h4200, 16'h4200, 16'h0000, 16'h4880);
      atb[3]  = mka(16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00);
      atb[4]  = mka(16'hFBFF, 16'h7BFF, 16'h0000, 16'hFC00);
      atb[5]  = mka(16'h7E01, 16'h3C00, 16'h0000, 16'h7E00);
      atb[6]  = mka(16'hBC00, 16'h7C00, 16'h7C00, 16'h7E00);
`ifdef PE_ZERO_GATING_EN
      atb[7]  = mka(16'h7C00, 16'h0000, 16'h3C00, 16'h3C00);
`else
      atb[7]  = mka(16'h7C00, 16'h0000, 16'h3C00, 16'h7E00);
`endif
      atb[8]  = mka(16'hC000, 16'h3C00, 16'h3C00, 16'hBC00);
      atb[9]  = mka(16'h1000, 16'h3C00, 16'h3C00, 16'h3C00);
      atb[10] = mka(16'h1000, 16'h3C00, 16'h3C01, 16'h3C02);
      atb[11] = mka(16'h0400, 16'h3800, 16'h3C00, 16'h3C00);
      atb[12] = mka(16'hBC00, 16'h3C00, 16'h3C01, 16'h1400);
      atb[13] = mka(16'hBC00, 16'h3C00, 16'h3C00, 16'h0000);
      atb[14] = mka(16'h0000, 16'h4000, 16'h3C00, 16'h3C00);
      atb[15] = mka(16'h3C01, 16'h3C01, 16'h0000, 16'h3C02);
      atb[16] = mka(16'h8000, 16'h4000, 16'h3C00, 16'h3C00);
      atb[17] = mka(16'h7BFF, 16'h3C00, 16'h7BFF, 16'h7C00);

      rstn  = 1'b0;
      thres = 2'd0;
      idle();
      #12;
      chk("reset_outputs", outs(), 50'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, tbl[i].en, tbl[i].sc, tbl[i].pen,
               tbl[i].csw, tbl[i].scan);
         tick();
         chk($sformatf("row%0d", i), outs(),
             {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ecsw, tbl[i].een});
      end

      // Stall for two cycles with a pair in stage 1; a switch on the first resumed edge must see nothing yet.
      drive(16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("stall_load_a", 50'(o_a), 50'h3C00);
      drive(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("stall1_ab", 50'({o_a, o_b}), 50'h3C003C00);
      tick();
      chk("stall2_ab", 50'({o_a, o_b}), 50'h3C003C00);
      drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("stall_resume_early", 50'(o_c), 50'h0000);
      chk("stall_resume_a", 50'(o_a), 50'h0000);
      idle();
      tick();
      tick();
      drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("stall_late_result", 50'(o_c), 50'h3C00);
      idle();
      tick();

      for (int i = 0; i < 18; i++) arith(i, atb[i]);

      // Asynchronous reset mid-cycle must clear outputs before the next edge.
      drive(16'h3C00, 16'h4000, 16'h4100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("pre_reset", outs(), {16'h3C00, 16'h4000, 16'h4100, 1'b0, 1'b1});
      #2;
      rstn = 1'b0;
      #1;
      chk("async_reset", outs(), 50'd0);
      idle();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      chk("after_reset", outs(), 50'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
